// File: rtl/digit_serial_pkg.sv
// Shared types and constants for the digit-serial add/sub/accumulate block.
// Also holds the one-bit full adder that the ripple slice is built from.
package digit_serial_pkg;

  localparam int DEF_DW   = 4;
  localparam int DEF_NDIG = 4;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Digit stream bus: input beat handshake with framing/mode, and the result
// handshake. The master drives operands; the slave returns result digits.
interface digit_serial_addsub_if #(
  parameter int DW = 4
) ();

  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic          in_last;
  logic [1:0]    mode;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          out_last;
  logic          out_carry;
  logic          overflow;

  modport master (
    output in_valid, in_first, in_last, mode, a, b, out_ready,
    input  in_ready, out_valid, sum, out_last, out_carry, overflow
  );

  modport slave (
    input  in_valid, in_first, in_last, mode, a, b, out_ready,
    output in_ready, out_valid, sum, out_last, out_carry, overflow
  );

endinterface

// File: rtl/digit_serial_addsub_slice.sv
// Combinational DW-bit ripple adder with carry-in; also exposes the carry
// into the most significant bit so the caller can form signed overflow.
module digit_adder_slice
  import digit_serial_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          cin,
  output logic [DW-1:0] s,
  output logic          cout,
  output logic          c_msb
);

  // Ripple chain of full adders, LSB to MSB.
  always_comb begin : p_ripple
    logic [DW:0] carry_s;
    logic [1:0]  fa_s;
    carry_s    = {(DW+1){1'b0}};
    carry_s[0] = cin;
    fa_s       = 2'b00;
    s          = {DW{1'b0}};
    for (int i = 0; i < DW; i++) begin
      fa_s           = full_add(x[i], y[i], carry_s[i]);
      s[i]           = fa_s[0];
      carry_s[i + 1] = fa_s[1];
    end
    cout  = carry_s[DW];
    c_msb = carry_s[DW-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor/accumulator: one DW-bit digit per accepted beat,
// LSD first, carry held between beats, single registered output stage.
module digit_serial_addsub
  import digit_serial_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NDIG = DEF_NDIG
) (
  input logic                clk,
  input logic                reset,
  digit_serial_addsub_if.slave bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e        state_r, state_nx;
  mode_e         mode_r, cur_mode_s;
  logic [IW-1:0] idx_r, cur_idx_s;
  logic          carry_r;
  logic [DW-1:0] acc_r [NDIG];

  logic          in_ready_s, accept_s, start_s, last_s, cin_s;
  logic          is_clr_s, cout_eff_s;
  logic [DW-1:0] y_s, s_s, res_s;
  logic          cout_s, c_msb_s;

  logic          out_valid_r, out_last_r, out_carry_r, overflow_r;
  logic [DW-1:0] sum_r;

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;

  digit_adder_slice #(.DW(DW)) u_slice (
    .x     (bus.a),
    .y     (y_s),
    .cin   (cin_s),
    .s     (s_s),
    .cout  (cout_s),
    .c_msb (c_msb_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next state: a last (explicit or forced) beat closes the word.
  always_comb begin
    state_nx = state_r;
    if (accept_s) begin
      if (last_s) begin
        state_nx = ST_IDLE;
      end else begin
        state_nx = ST_BUSY;
      end
    end else begin
      state_nx = state_r;
    end
  end

  // FSM outputs: select mode, digit index, carry-in and second operand for this beat.
  always_comb begin
    start_s = (state_r == ST_IDLE) || bus.in_first;
    if (start_s) begin
      cur_mode_s = mode_e'(bus.mode);
      cur_idx_s  = {IW{1'b0}};
      cin_s      = (mode_e'(bus.mode) == MODE_SUB);
    end else begin
      cur_mode_s = mode_r;
      cur_idx_s  = idx_r;
      cin_s      = carry_r;
    end
    last_s   = bus.in_last || (cur_idx_s == IW'(NDIG - 1));
    is_clr_s = (cur_mode_s == MODE_CLR);
    case (cur_mode_s)
      MODE_ADD: y_s = bus.b;
      MODE_SUB: y_s = ~bus.b;
      MODE_ACC: y_s = acc_r[cur_idx_s];
      MODE_CLR: y_s = {DW{1'b0}};
      default:  y_s = bus.b;
    endcase
    if (is_clr_s) begin
      res_s      = {DW{1'b0}};
      cout_eff_s = 1'b0;
    end else begin
      res_s      = s_s;
      cout_eff_s = cout_s;
    end
  end

  // Per-word context: latched mode, digit index and inter-beat carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r  <= MODE_ADD;
      idx_r   <= {IW{1'b0}};
      carry_r <= 1'b0;
    end else if (accept_s) begin
      mode_r <= cur_mode_s;
      if (last_s) begin
        idx_r   <= {IW{1'b0}};
        carry_r <= 1'b0;
      end else begin
        idx_r   <= cur_idx_s + IW'(1);
        carry_r <= cout_eff_s;
      end
    end else begin
      mode_r  <= mode_r;
      idx_r   <= idx_r;
      carry_r <= carry_r;
    end
  end

  // Accumulator digits: only the digit addressed by this beat is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) begin
        acc_r[i] <= {DW{1'b0}};
      end
    end else if (accept_s) begin
      case (cur_mode_s)
        MODE_ACC: acc_r[cur_idx_s] <= s_s;
        MODE_CLR: acc_r[cur_idx_s] <= {DW{1'b0}};
        default:  acc_r[cur_idx_s] <= acc_r[cur_idx_s];
      endcase
    end else begin
      acc_r[cur_idx_s] <= acc_r[cur_idx_s];
    end
  end

  // Output register: loads on acceptance, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      sum_r       <= {DW{1'b0}};
      out_last_r  <= 1'b0;
      out_carry_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      sum_r       <= res_s;
      out_last_r  <= last_s;
      out_carry_r <= last_s && cout_eff_s;
      overflow_r  <= last_s && !is_clr_s && (c_msb_s ^ cout_s);
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_carry = out_carry_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised, clocked successor to the team's combinational 4-bit ripple adder.
- Adds, subtracts or accumulates multi-digit words one DW-bit digit per beat, least-significant digit first.
- The carry is held in a register between beats.
- Valid/ready handshake on input and output, so the block can sit behind the 8-pin TinyTapeout io wrapper, which feeds digits serially.

Parameters:
- DW, 4, digit width in bits (>=2).
- NDIG, 4, maximum digits per word; also the accumulator depth in digits (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat offered.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_first  in  1  beat is digit 0 of a word.
- in_last  in  1  beat is final digit of a word.
- mode  in  2  00 ADD a+b, 01 SUB a-b, 10 ACC acc+a, 11 CLR; sampled on the first beat only.
- a  in  DW  operand A digit.
- b  in  DW  operand B digit (ignored in ACC/CLR).
- out_valid  out  1  result digit available.
- out_ready  in  1  downstream accepts result.
- sum  out  DW  result digit.
- out_last  out  1  result digit is last of word.
- out_carry  out  1  carry-out of the last digit (SUB: 1 = no borrow); 0 on non-last beats.
- overflow  out  1  signed overflow of the whole word; valid with out_last, 0 otherwise.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, sum=0, out_last=0, out_carry=0, overflow=0, carry_q=0, idx=0, state=IDLE, all NDIG accumulator digits=0. A reset mid-word discards the word and any pending output.
- in_ready = !out_valid || out_ready, which gives a single output register with no bubble under continuous flow.
- Latency: accepted beat -> result on the next cycle (out_valid=1). sum, out_* and overflow stay stable while out_valid && !out_ready.
- FSM has two states, IDLE and BUSY:
  - IDLE: any accepted beat starts a word. in_first is implied. mode is latched into mode_q. idx=0. Carry-in = 1 if SUB, else 0.
  - BUSY + in_first: the current word is aborted with no output flag. The new word restarts at idx=0 with newly latched mode.
  - BUSY, no in_first: uses mode_q and carry-in = carry_q, then idx++.
  - A beat with in_last, or a beat at idx==NDIG-1 (forced last), produces out_last=1 and returns to IDLE. carry_q is cleared and idx reset.
- Per-digit arithmetic: {cout,s} = x + y + cin, where:
  - ADD: x=a, y=b.
  - SUB: x=a, y=~b.
  - ACC: x=a, y=acc[idx]; acc[idx]<=s on acceptance.
  - CLR: s=0, acc[idx]<=0, cout=0.
- overflow on last digit = carry into digit MSB XOR cout. out_carry = cout. Both are forced to 0 in CLR.
- ACC/CLR index the accumulator by idx, so a shorter word touches only its low digits and leaves the upper digits unchanged.
- Simultaneous in_first and in_last: single-digit word.
- No state changes on cycles without acceptance, including while stalled by out_ready=0.

Decomposition:
- Package digit_serial_pkg: mode enum (MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR), state enum (ST_IDLE, ST_BUSY), default DW/NDIG constants.
- Sub-module digit_adder_slice: combinational DW-bit adder with cin. Outputs s, cout and c_msb (carry into MSB). Built as a ripple of full adders, the same structure as the existing 4-bit adder.
- The top holds the FSM, idx counter, carry_q, accumulator array and output register.

Test Plan:
- ADD single digit: first=last=1, a=9, b=8 -> sum=1, out_carry=1, overflow=1, out_last=1 one cycle after acceptance.
- ADD 0x00FF+0x0001 over 4 beats (a=F,F,0,0; b=1,0,0,0) -> sums 0,0,1,0; last beat out_carry=0, overflow=0.
- SUB 0x03-0x05, 2 digits (a=3,0; b=5,0) -> sums E,F; out_carry=0 (borrow), overflow=0.
- ACC sequence: CLR word (4 beats), then ACC a=9,0,0,0 twice -> second word outputs 2,1,0,0 (0x0012); 5 beats without in_last -> 4th beat has out_last=1 and the 5th starts a new word with carry-in 0.
- Backpressure: hold out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, sum/out_last unchanged, carry_q unchanged; release -> next beat continues the word correctly.
- Reset after 2 of 4 ADD digits -> next cycle out_valid=0, accumulator zero; following first beat a=1, b=1 -> sum=2 (no stale carry); in_first mid-word aborts cleanly with the same result.
